// File: rtl/sin_pkg.sv
// ---------------------------------------------------------------------------
// sin_pkg
// Constants shared by every consumer of the pipelined `sinus` core.
//   SIN_LATENCY : sinus latency in clk_en-qualified cycles
//   FLOAT_W     : IEEE-754 single-precision operand/result width
// ---------------------------------------------------------------------------
package sin_pkg;
   localparam int SIN_LATENCY = 36;
   localparam int FLOAT_W     = 32;
endpackage

// File: rtl/sin_arbiter_if.sv
// ---------------------------------------------------------------------------
// sin_arbiter_if
// Requester-side bus of the shared sine scheduler.
//   req        : per-requester request, held until ack
//   req_data   : packed operands, requester i at [32i+31:32i]
//   ack        : one-hot grant
//   busy       : requester has an operation in flight
//   resp_valid : one-hot, one-cycle result strobe
//   resp_data  : sine result, valid while some resp_valid bit is high
// master = effect requesters, slave = sin_arbiter.
// ---------------------------------------------------------------------------
interface sin_arbiter_if
   import sin_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]         req;
   logic [NUM_REQ*FLOAT_W-1:0] req_data;
   logic [NUM_REQ-1:0]         ack;
   logic [NUM_REQ-1:0]         busy;
   logic [NUM_REQ-1:0]         resp_valid;
   logic [FLOAT_W-1:0]         resp_data;

   modport master (
      output req, req_data,
      input  ack, busy, resp_valid, resp_data
   );

   modport slave (
      input  req, req_data,
      output ack, busy, resp_valid, resp_data
   );
endinterface

// File: rtl/sin_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker.
//   elig      : eligible requesters
//   rr_ptr    : index with highest priority this cycle
//   grant     : one-hot grant (zero when nothing is eligible)
//   grant_idx : binary index of the grant
//   any       : some requester is eligible
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         elig,
   input  logic [$clog2(N)-1:0] rr_ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 any
);
   localparam int IDX_W = $clog2(N);

   int   best_d_s;
   int   dist_s;
   logic take_s;

   // Pick the eligible index with the smallest wrapped distance from rr_ptr;
   // scanning by position keeps every vector index a constant.
   always_comb begin
      best_d_s  = N;
      dist_s    = 0;
      take_s    = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         dist_s    = (i + N - int'(rr_ptr)) % N;
         take_s    = elig[i] && (dist_s < best_d_s);
         best_d_s  = take_s ? dist_s : best_d_s;
         grant_idx = take_s ? IDX_W'(i) : grant_idx;
      end
   end

   assign any = |elig;

   // Expand the winning index to a one-hot grant.
   always_comb begin
      grant = '0;
      for (int i = 0; i < N; i++) begin
         grant[i] = any && (grant_idx == IDX_W'(i));
      end
   end
endmodule

// File: rtl/sin_arbiter.sv
// ---------------------------------------------------------------------------
// sin_arbiter
// Shares one pipelined `sinus` core among NUM_REQ requesters. One operand is
// issued per cycle at most; a {valid, tag} shadow pipeline of LATENCY stages
// follows the core so each result is strobed back to its issuer.
//   clock, reset_n : clock, asynchronous active-low reset
//   rbus           : requester bus (sin_arbiter_if.slave)
//   core_clk_en    : sinus.clk_en, high only while work is in flight
//   core_data      : sinus.data (registered)
//   core_result    : sinus.result
// ---------------------------------------------------------------------------
module sin_arbiter
   import sin_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int LATENCY = SIN_LATENCY
) (
   input  logic               clock,
   input  logic               reset_n,
   sin_arbiter_if.slave       rbus,
   output logic               core_clk_en,
   output logic [FLOAT_W-1:0] core_data,
   input  logic [FLOAT_W-1:0] core_result
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] elig_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0]   grant_idx_s;
   logic               any_s;
   logic [NUM_REQ-1:0] ack_s;
   logic [NUM_REQ-1:0] resp_valid_s;
   logic [FLOAT_W-1:0] opnd_s;
   logic               core_clk_en_s;

   logic [IDX_W-1:0]   rr_ptr_r;
   logic [NUM_REQ-1:0] busy_r;
   logic               issue_v_r;
   logic [IDX_W-1:0]   issue_tag_r;
   logic [FLOAT_W-1:0] core_data_r;
   logic [LATENCY-1:0] stage_v_r;
   logic [IDX_W-1:0]   stage_tag_r [LATENCY];

   // A requester with an operation in flight may not issue again.
   assign elig_s = rbus.req & ~busy_r;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .elig      (elig_s),
      .rr_ptr    (rr_ptr_r),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any       (any_s)
   );

   // Grants are suppressed while reset is asserted so no ack leaks out.
   assign ack_s = reset_n ? grant_s : {NUM_REQ{1'b0}};

   // Select the granted requester's operand.
   always_comb begin
      opnd_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         opnd_s = (grant_idx_s == IDX_W'(i)) ? rbus.req_data[i*FLOAT_W +: FLOAT_W] : opnd_s;
      end
   end

   // Decode the tag leaving the last stage into a one-hot response strobe.
   always_comb begin
      resp_valid_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         resp_valid_s[i] = stage_v_r[LATENCY-1] && (stage_tag_r[LATENCY-1] == IDX_W'(i));
      end
   end

   // Core runs only while something is issued or in flight; never stalled.
   assign core_clk_en_s = issue_v_r | (|stage_v_r);

   // Issue register: operand, issue tag and round-robin pointer.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         core_data_r <= '0;
         issue_v_r   <= 1'b0;
         issue_tag_r <= '0;
         rr_ptr_r    <= '0;
      end else if (any_s) begin
         core_data_r <= opnd_s;
         issue_v_r   <= 1'b1;
         issue_tag_r <= grant_idx_s;
         rr_ptr_r    <= (grant_idx_s == IDX_W'(NUM_REQ-1)) ? IDX_W'(0) : grant_idx_s + IDX_W'(1);
      end else begin
         issue_v_r   <= 1'b0;
      end
   end

   // Busy flags: set on ack, cleared on the edge that ends the response cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy_r <= '0;
      end else begin
         busy_r <= (busy_r & ~resp_valid_s) | ack_s;
      end
   end

   // Tag shadow pipeline, advanced in lock-step with the core's clk_en.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stage_v_r <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            stage_tag_r[k] <= '0;
         end
      end else if (core_clk_en_s) begin
         stage_v_r      <= {stage_v_r[LATENCY-2:0], issue_v_r};
         stage_tag_r[0] <= issue_tag_r;
         for (int k = 1; k < LATENCY; k++) begin
            stage_tag_r[k] <= stage_tag_r[k-1];
         end
      end
   end

   assign rbus.ack        = ack_s;
   assign rbus.busy       = busy_r;
   assign rbus.resp_valid = resp_valid_s;
   assign rbus.resp_data  = core_result;
   assign core_clk_en     = core_clk_en_s;
   assign core_data       = core_data_r;
endmodule

// File: tb/tb_sin_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sin_arbiter
// Directed bench for sin_arbiter with a behavioural 36-stage sinus model.
// Scenario table drives requesters; expected events and sample points are
// hand-computed tables.
// ---------------------------------------------------------------------------
module tb_sin_arbiter;
   import sin_pkg::*;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        core_clk_en;
   logic [31:0] core_data;
   logic [31:0] core_result;
   logic [31:0] core_pipe [SIN_LATENCY];

   always #5 clock = ~clock;

   sin_arbiter_if #(.NUM_REQ(4)) bus ();

   sin_arbiter #(.NUM_REQ(4), .LATENCY(SIN_LATENCY)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .rbus        (bus),
      .core_clk_en (core_clk_en),
      .core_data   (core_data),
      .core_result (core_result)
   );

   // Known sine values of the test operands (float pi -> -8.74e-8).
   function automatic logic [31:0] sin_lut(input logic [31:0] x);
      case (x)
         32'h00000000: sin_lut = 32'h00000000;
         32'h3F060A92: sin_lut = 32'h3F000000;
         32'h3FC90FDB: sin_lut = 32'h3F800000;
         32'h40490FDB: sin_lut = 32'hB3BBBD2E;
         default:      sin_lut = x ^ 32'hA5A5A5A5;
      endcase
   endfunction

   // Behavioural sinus core: not reset, advances only on clk_en.
   always @(posedge clock) begin
      if (core_clk_en) begin
         core_pipe[0] <= core_data;
         for (int k = 1; k < SIN_LATENCY; k++) core_pipe[k] <= core_pipe[k-1];
      end
   end
   assign core_result = sin_lut(core_pipe[SIN_LATENCY-1]);

   typedef struct {
      logic [3:0]   mask0;
      logic [127:0] ops;
      int           mode;      // 0 drop after ack, 1 re-request after resp, 2 hold
      int           rst_cyc;   // -1: no mid-run reset
      logic [3:0]   mask_after;
      int           len;
   } scn_t;

   typedef struct {
      int          scen;
      logic        is_resp;
      int          cyc;
      int          idx;
      logic [31:0] data;
   } ev_t;

   typedef struct {
      int          scen;
      int          cyc;
      logic [3:0]  busy;
      logic        clk_en;
      logic        chk_cd;
      logic [31:0] cd;
   } smp_t;

   scn_t scn [5];
   ev_t  exp_ev [$];
   ev_t  obs_ev [$];
   smp_t smp [$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      bus.req = 4'b0000;
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic run_scn(input int s);
      logic [3:0] pend;
      int         onehot_bad;
      ev_t        ex [$];
      ev_t        ob;
      logic       ok;
      do_reset();
      pend       = 4'b0000;
      onehot_bad = 0;
      obs_ev.delete();
      bus.req_data = scn[s].ops;
      for (int c = 0; c < scn[s].len; c++) begin
         tick();
         if (c == 0) pend = scn[s].mask0;
         if (scn[s].rst_cyc >= 0 && c == scn[s].rst_cyc) reset_n = 1'b0;
         if (scn[s].rst_cyc >= 0 && c == scn[s].rst_cyc + 2) begin
            reset_n = 1'b1;
            pend    = pend | scn[s].mask_after;
         end
         bus.req = pend;
         #1;
         foreach (smp[k]) begin
            if (smp[k].scen == s && smp[k].cyc == c) begin
               chk($sformatf("s%0d c%0d busy", s, c), {28'h0, bus.busy}, {28'h0, smp[k].busy});
               chk($sformatf("s%0d c%0d core_clk_en", s, c), {31'h0, core_clk_en}, {31'h0, smp[k].clk_en});
               if (smp[k].chk_cd) chk($sformatf("s%0d c%0d core_data", s, c), core_data, smp[k].cd);
            end
         end
         if ($countones(bus.ack) > 1 || $countones(bus.resp_valid) > 1) onehot_bad++;
         for (int i = 0; i < 4; i++) begin
            if (bus.ack[i]) begin
               obs_ev.push_back(ev_t'{s, 1'b0, c, i, 32'h0});
               if (scn[s].mode != 2) pend[i] = 1'b0;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (bus.resp_valid[i]) begin
               obs_ev.push_back(ev_t'{s, 1'b1, c, i, bus.resp_data});
               if (scn[s].mode == 1) pend[i] = 1'b1;
            end
         end
      end
      foreach (exp_ev[k]) if (exp_ev[k].scen == s) ex.push_back(exp_ev[k]);
      chk($sformatf("s%0d event_count", s), obs_ev.size(), ex.size());
      chk($sformatf("s%0d onehot", s), onehot_bad, 0);
      for (int k = 0; k < ex.size(); k++) begin
         n_total++;
         if (k >= obs_ev.size()) begin
            $display("FAIL s%0d event%0d: got none expected resp=%0d cyc=%0d idx=%0d",
                     s, k, ex[k].is_resp, ex[k].cyc, ex[k].idx);
         end else begin
            ob = obs_ev[k];
            ok = (ob.is_resp == ex[k].is_resp) && (ob.cyc == ex[k].cyc) && (ob.idx == ex[k].idx) &&
                 (!ex[k].is_resp || ob.data === ex[k].data);
            if (ok) n_pass++;
            else $display("FAIL s%0d event%0d: got resp=%0d cyc=%0d idx=%0d data=%h expected resp=%0d cyc=%0d idx=%0d data=%h",
                          s, k, ob.is_resp, ob.cyc, ob.idx, ob.data,
                          ex[k].is_resp, ex[k].cyc, ex[k].idx, ex[k].data);
         end
      end
   endtask

   initial begin
      int bad_ce;
      int bad_cd;
      int bad_o;
      for (int k = 0; k < SIN_LATENCY; k++) core_pipe[k] = 32'h0;

      // Scenarios: single, all four, fairness, busy masking, mid-flight reset.
      scn[0] = '{4'b0001, {96'h0, 32'h3FC90FDB}, 0, -1, 4'b0000, 40};
      scn[1] = '{4'b1111, {32'h40490FDB, 32'h3FC90FDB, 32'h3F060A92, 32'h00000000}, 0, -1, 4'b0000, 43};
      scn[2] = '{4'b0110, {32'h0, 32'h3FC90FDB, 32'h3F060A92, 32'h0}, 1, -1, 4'b0000, 80};
      scn[3] = '{4'b0001, {96'h0, 32'h3FC90FDB}, 2, -1, 4'b0000, 78};
      scn[4] = '{4'b0011, {32'h0, 32'h40490FDB, 32'h3F060A92, 32'h3FC90FDB}, 0, 20, 4'b0101, 63};

      exp_ev.push_back(ev_t'{0, 1'b0,  0, 0, 32'h0});
      exp_ev.push_back(ev_t'{0, 1'b1, 37, 0, 32'h3F800000});

      exp_ev.push_back(ev_t'{1, 1'b0,  0, 0, 32'h0});
      exp_ev.push_back(ev_t'{1, 1'b0,  1, 1, 32'h0});
      exp_ev.push_back(ev_t'{1, 1'b0,  2, 2, 32'h0});
      exp_ev.push_back(ev_t'{1, 1'b0,  3, 3, 32'h0});
      exp_ev.push_back(ev_t'{1, 1'b1, 37, 0, 32'h00000000});
      exp_ev.push_back(ev_t'{1, 1'b1, 38, 1, 32'h3F000000});
      exp_ev.push_back(ev_t'{1, 1'b1, 39, 2, 32'h3F800000});
      exp_ev.push_back(ev_t'{1, 1'b1, 40, 3, 32'hB3BBBD2E});

      exp_ev.push_back(ev_t'{2, 1'b0,  0, 1, 32'h0});
      exp_ev.push_back(ev_t'{2, 1'b0,  1, 2, 32'h0});
      exp_ev.push_back(ev_t'{2, 1'b1, 37, 1, 32'h3F000000});
      exp_ev.push_back(ev_t'{2, 1'b0, 38, 1, 32'h0});
      exp_ev.push_back(ev_t'{2, 1'b1, 38, 2, 32'h3F800000});
      exp_ev.push_back(ev_t'{2, 1'b0, 39, 2, 32'h0});
      exp_ev.push_back(ev_t'{2, 1'b1, 75, 1, 32'h3F000000});
      exp_ev.push_back(ev_t'{2, 1'b0, 76, 1, 32'h0});
      exp_ev.push_back(ev_t'{2, 1'b1, 76, 2, 32'h3F800000});
      exp_ev.push_back(ev_t'{2, 1'b0, 77, 2, 32'h0});

      exp_ev.push_back(ev_t'{3, 1'b0,  0, 0, 32'h0});
      exp_ev.push_back(ev_t'{3, 1'b1, 37, 0, 32'h3F800000});
      exp_ev.push_back(ev_t'{3, 1'b0, 38, 0, 32'h0});
      exp_ev.push_back(ev_t'{3, 1'b1, 75, 0, 32'h3F800000});
      exp_ev.push_back(ev_t'{3, 1'b0, 76, 0, 32'h0});

      exp_ev.push_back(ev_t'{4, 1'b0,  0, 0, 32'h0});
      exp_ev.push_back(ev_t'{4, 1'b0,  1, 1, 32'h0});
      exp_ev.push_back(ev_t'{4, 1'b0, 22, 0, 32'h0});
      exp_ev.push_back(ev_t'{4, 1'b0, 23, 2, 32'h0});
      exp_ev.push_back(ev_t'{4, 1'b1, 59, 0, 32'h3F800000});
      exp_ev.push_back(ev_t'{4, 1'b1, 60, 2, 32'hB3BBBD2E});

      smp.push_back(smp_t'{0,  0, 4'b0000, 1'b0, 1'b1, 32'h00000000});
      smp.push_back(smp_t'{0,  1, 4'b0001, 1'b1, 1'b1, 32'h3FC90FDB});
      smp.push_back(smp_t'{0, 37, 4'b0001, 1'b1, 1'b0, 32'h0});
      smp.push_back(smp_t'{0, 38, 4'b0000, 1'b0, 1'b1, 32'h3FC90FDB});
      smp.push_back(smp_t'{1,  1, 4'b0001, 1'b1, 1'b1, 32'h00000000});
      smp.push_back(smp_t'{1,  2, 4'b0011, 1'b1, 1'b1, 32'h3F060A92});
      smp.push_back(smp_t'{1,  4, 4'b1111, 1'b1, 1'b1, 32'h40490FDB});
      smp.push_back(smp_t'{1, 38, 4'b1110, 1'b1, 1'b0, 32'h0});
      smp.push_back(smp_t'{1, 40, 4'b1000, 1'b1, 1'b0, 32'h0});
      smp.push_back(smp_t'{1, 41, 4'b0000, 1'b0, 1'b1, 32'h40490FDB});
      smp.push_back(smp_t'{3, 37, 4'b0001, 1'b1, 1'b0, 32'h0});
      smp.push_back(smp_t'{3, 38, 4'b0000, 1'b0, 1'b0, 32'h0});
      smp.push_back(smp_t'{3, 39, 4'b0001, 1'b1, 1'b0, 32'h0});
      smp.push_back(smp_t'{4, 19, 4'b0011, 1'b1, 1'b0, 32'h0});
      smp.push_back(smp_t'{4, 20, 4'b0000, 1'b0, 1'b0, 32'h0});
      smp.push_back(smp_t'{4, 21, 4'b0000, 1'b0, 1'b0, 32'h0});
      smp.push_back(smp_t'{4, 22, 4'b0000, 1'b0, 1'b1, 32'h00000000});
      smp.push_back(smp_t'{4, 23, 4'b0001, 1'b1, 1'b1, 32'h3FC90FDB});

      // Reset state, with every requester asking during reset.
      bus.req      = 4'b1111;
      bus.req_data = {32'h40490FDB, 32'h3FC90FDB, 32'h3F060A92, 32'h00000000};
      reset_n      = 1'b0;
      tick();
      tick();
      chk("reset ack",         {28'h0, bus.ack},        32'h0);
      chk("reset busy",        {28'h0, bus.busy},       32'h0);
      chk("reset resp_valid",  {28'h0, bus.resp_valid}, 32'h0);
      chk("reset core_clk_en", {31'h0, core_clk_en},    32'h0);
      chk("reset core_data",   core_data,               32'h0);

      for (int s = 0; s < 5; s++) run_scn(s);

      // Idle gating after the last response: core off, operand held.
      bad_ce = 0;
      bad_cd = 0;
      bad_o  = 0;
      for (int c = 0; c < 100; c++) begin
         tick();
         bus.req = 4'b0000;
         #1;
         if (core_clk_en !== 1'b0) bad_ce++;
         if (core_data !== 32'h40490FDB) bad_cd++;
         if (bus.ack !== 4'b0000 || bus.resp_valid !== 4'b0000) bad_o++;
      end
      chk("idle core_clk_en cycles", bad_ce, 0);
      chk("idle core_data cycles",   bad_cd, 0);
      chk("idle ack/resp cycles",    bad_o,  0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
